sprite_motion_ctrl: RTL and testbench

Frame-synchronous controller that turns PS/2 key events into sprite position and sprite-index updates for the pixel selector. Tracks held WASD keys and pending SPACE presses between frames, then commits one bounded move and at most one index step per frame, only at the start of vertical blank. Sits between `hps_io` (`ps2_key`) and `pixel_selector` (`current_sprite_x/y`, `sprite_index`), so sprite state never changes during active video.

---
 rtl/sprite_motion_ctrl.sv | 79 +++++++
 tb/tb_sprite_motion_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: turns PS/2 key events into per-frame sprite moves and index steps,
// committed only at the vblank rising edge so sprite state never changes in active video.
module sprite_motion_ctrl #(
    parameter int MAX_X    = 1279,
    parameter int MAX_Y    = 719,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int STEP     = 1,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        vblank,
    output logic [10:0] sprite_x,
    output logic [9:0]  sprite_y,
    output logic [3:0]  sprite_index,
    output logic        frame_update,
    output logic [4:0]  keys_held
);
    localparam int X_LIM = MAX_X - SPRITE_W + 1;
    localparam int Y_LIM = MAX_Y - SPRITE_H + 1;

    typedef enum logic [1:0] {WAIT_VB, APPLY, DONE} state_t;
    state_t state, state_nx;

    logic              prev, primed, space_pending, vblank_d, ev;
    logic [4:0]        hit;
    logic signed [11:0] dx, nx;
    logic signed [10:0] dy, ny;
    logic [10:0]       x_cl;
    logic [9:0]        y_cl;

    // the first cycle after reset only primes prev, so a stale toggle level is not an event
    assign ev = primed && (ps2_key[10] != prev) && !ps2_key[8];

    always_comb begin
        hit = {ps2_key[7:0] == 8'h29, ps2_key[7:0] == 8'h23, ps2_key[7:0] == 8'h1B,
               ps2_key[7:0] == 8'h1C, ps2_key[7:0] == 8'h1D} & {5{ev}};
        dx = (keys_held[3] && !keys_held[1]) ? 12'(STEP) : (keys_held[1] && !keys_held[3]) ? 12'(-STEP) : 12'sd0;
        dy = (keys_held[2] && !keys_held[0]) ? 11'(STEP) : (keys_held[0] && !keys_held[2]) ? 11'(-STEP) : 11'sd0;
        nx = $signed({1'b0, sprite_x}) + dx;
        ny = $signed({1'b0, sprite_y}) + dy;
        x_cl = (nx < 0) ? 11'd0 : (nx > X_LIM) ? 11'(X_LIM) : nx[10:0];
        y_cl = (ny < 0) ? 10'd0 : (ny > Y_LIM) ? 10'(Y_LIM) : ny[9:0];
        state_nx = (state == WAIT_VB) ? ((vblank && !vblank_d) ? APPLY : WAIT_VB) :
                   (state == APPLY) ? DONE : WAIT_VB;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_VB;
            prev          <= 1'b0;
            primed        <= 1'b0;
            vblank_d      <= 1'b0;
            keys_held     <= '0;
            space_pending <= 1'b0;
            sprite_x      <= 11'(INIT_X);
            sprite_y      <= 10'(INIT_Y);
            sprite_index  <= '0;
            frame_update  <= 1'b0;
        end else begin
            state         <= state_nx;
            prev          <= ps2_key[10];
            primed        <= 1'b1;
            vblank_d      <= vblank;
            keys_held     <= ps2_key[9] ? (keys_held | hit) : (keys_held & ~hit);
            // a press landing in the APPLY cycle wins over the consume, deferring it a frame
            space_pending <= (hit[4] && ps2_key[9]) || (space_pending && state != APPLY);
            frame_update  <= state == DONE;
            if (state == APPLY) begin
                sprite_x     <= x_cl;
                sprite_y     <= y_cl;
                sprite_index <= sprite_index + 4'(space_pending);
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed self-checking bench for sprite_motion_ctrl.
module tb_sprite_motion_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        vblank;
    logic [10:0] sprite_x;
    logic [9:0]  sprite_y;
    logic [3:0]  sprite_index;
    logic        frame_update;
    logic [4:0]  keys_held;
    int          passed = 0;
    int          total = 0;

    sprite_motion_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .vblank(vblank),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_index(sprite_index),
        .frame_update(frame_update), .keys_held(keys_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_key(input logic press, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], press, ext, code};
    endtask

    task automatic send(input logic press, input logic ext, input logic [7:0] code);
        set_key(press, ext, code);
        @(negedge clk);
    endtask

    // one vblank rise; optionally a SPACE press lands exactly on the APPLY edge
    task automatic frame(input bit sp);
        int n = 0;
        int at = -1;
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1 && sp) set_key(1'b1, 1'b0, 8'h29);
            @(negedge clk);
            if (i == 3) vblank = 1'b0;
            if (frame_update) begin
                n++;
                if (at < 0) at = i;
            end
        end
        chk("pulse_count", n, 1);
        chk("pulse_cycle", at, 2);
    endtask

    initial begin
        reset_n = 1'b0;
        vblank  = 1'b0;
        ps2_key = 11'h623;
        repeat (3) @(negedge clk);
        chk("rst_x", sprite_x, 100);
        chk("rst_y", sprite_y, 100);
        chk("rst_idx", sprite_index, 0);
        chk("rst_fu", frame_update, 0);
        chk("rst_keys", keys_held, 0);
        reset_n = 1'b1;
        @(negedge clk);
        repeat (3) frame(0);
        chk("noev_keys", keys_held, 0);
        chk("noev_x", sprite_x, 100);
        chk("noev_y", sprite_y, 100);
        chk("noev_idx", sprite_index, 0);

        send(1'b1, 1'b0, 8'h23);
        chk("d_held", keys_held, 5'b01000);
        repeat (5) frame(0);
        chk("d5_x", sprite_x, 105);
        chk("d5_y", sprite_y, 100);
        send(1'b0, 1'b0, 8'h23);
        chk("d_rel", keys_held, 0);

        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h23);
        chk("ad_held", keys_held, 5'b01010);
        repeat (4) frame(0);
        chk("ad_x", sprite_x, 105);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h23);

        send(1'b1, 1'b0, 8'h1D);
        chk("w_held", keys_held, 5'b00001);
        repeat (98) frame(0);
        chk("w_y2", sprite_y, 2);
        repeat (5) frame(0);
        chk("w_y0", sprite_y, 0);
        chk("w_x", sprite_x, 105);
        send(1'b0, 1'b0, 8'h1D);

        send(1'b1, 1'b0, 8'h23);
        repeat (1141) frame(0);
        chk("d_x1246", sprite_x, 1246);
        repeat (4) frame(0);
        chk("d_xsat", sprite_x, 1248);
        chk("d_ysat", sprite_y, 0);
        send(1'b0, 1'b0, 8'h23);

        send(1'b1, 1'b0, 8'h29);
        chk("sp_held", keys_held, 5'b10000);
        send(1'b0, 1'b0, 8'h29);
        send(1'b1, 1'b0, 8'h29);
        send(1'b0, 1'b0, 8'h29);
        send(1'b1, 1'b0, 8'h29);
        send(1'b0, 1'b0, 8'h29);
        frame(0);
        chk("sp3_idx", sprite_index, 1);
        frame(0);
        chk("sp_once", sprite_index, 1);
        for (int i = 0; i < 14; i++) begin
            send(1'b1, 1'b0, 8'h29);
            frame(0);
        end
        chk("sp_idx15", sprite_index, 15);
        send(1'b1, 1'b0, 8'h29);
        frame(0);
        chk("sp_wrap", sprite_index, 0);

        send(1'b1, 1'b0, 8'h29);
        frame(1);
        chk("apply_sp1", sprite_index, 1);
        frame(0);
        chk("apply_sp2", sprite_index, 2);
        frame(0);
        chk("apply_sp3", sprite_index, 2);
        send(1'b0, 1'b0, 8'h29);
        chk("sp_rel", keys_held, 0);

        send(1'b1, 1'b1, 8'h1C);
        chk("ext_keys", keys_held, 0);
        send(1'b1, 1'b0, 8'h5A);
        chk("unk_keys", keys_held, 0);
        frame(0);
        chk("ign_x", sprite_x, 1248);
        chk("ign_y", sprite_y, 0);

        send(1'b1, 1'b0, 8'h23);
        vblank = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_x", sprite_x, 100);
        chk("mid_y", sprite_y, 100);
        chk("mid_fu", frame_update, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_fu_hold", frame_update, 0);
        end
        chk("mid_keys", keys_held, 0);
        vblank = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        frame(0);
        chk("post_x", sprite_x, 100);
        chk("post_idx", sprite_index, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
